calc_ctrl: RTL and testbench
============================

# calc_ctrl

Keyboard-driven sequencer for the two-operand calculator datapath. Decodes PS/2 numpad press events into two 2-digit decimal operands and an operator, hands the job to the external multi-cycle arithmetic unit over a start/done handshake, and latches the result for the seven-segment display path. Sits between the keyboard decoder (`key_valid`/`key_down`/`last_change`) and the ALU/display blocks.

## Interface
- `TIMEOUT`, 1023: max cycles spent waiting for `alu_done`; used only when `CALC_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle pulse per keyboard event.
- `key_down`  in  512  pressed-key bitmap.
- `last_change`  in  8  scan code of the latest event.
- `alu_start`  out  1  one-cycle job request.
- `alu_a`, `alu_b`  out  7  operands, binary 0..99.
- `alu_op`  out  2  0 add, 1 sub, 2 mul.
- `alu_done`  in  1  one-cycle completion pulse.
- `alu_value`  in  14  result magnitude.
- `alu_neg`  in  1  result negative (sub only).
- `in0`, `in1`, `in2`, `in3`  out  4  A tens, A units, B tens, B units (BCD).
- `calculate`  out  4  operator code: 10 add, 11 sub, 12 mul, 0 none.
- `value`  out  14  latched result.
- `sign`  out  4  11 when result negative, else 0.
- `err`  out  1  result invalid (timeout).
- `state`  out  3  current FSM state.

## Operation
- Press event = `key_valid & key_down[last_change]`, sampled on `clk`. At most one event per cycle. Non-events and unlisted codes are ignored.
- Digit codes 0..9: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D. Add 79, sub 7B, mul 7C, Enter 5A, Esc 76 (all hex).
- Digit entry uses a shift-in, max 2 digits per operand. The first digit sets units = d and tens = 0. The second digit moves units to tens and sets units = d. A third digit is ignored.
- States:
  - S_A (0): digits fill `in0`/`in1`. An operator with ≥1 A digit latches `calculate` and goes to S_B. An operator with 0 A digits is ignored.
  - S_B (1): digits fill `in2`/`in3`. Enter with ≥1 B digit goes to S_ISSUE. Operator keys are ignored.
  - S_ISSUE (2): `alu_start`=1 for exactly this cycle. Next state is S_WAIT unconditionally.
  - S_WAIT (3): on `alu_done`, latch `value`=`alu_value`, `sign`=`alu_neg`?11:0, `err`=0, then go to S_SHOW.
  - S_SHOW (4): display the result. A digit clears all operands/`calculate`, loads that digit as A units, and goes to S_A. Esc clears and goes to S_A.
- Esc in S_A/S_B/S_SHOW: `in0..in3`=0, `calculate`=0, digit counts=0, go to S_A. `value`/`sign`/`err` are kept.
- Esc in S_ISSUE/S_WAIT is ignored; the ALU owns the operands.
- `alu_a` = `in0`*10+`in1`; `alu_b` = `in2`*10+`in3`; `alu_op` = `calculate`-10. All are registered and held stable from S_ISSUE until leaving S_WAIT.
- `alu_done` outside S_WAIT is ignored.

## Timing
- Reset values:
  - `state`=S_A; `in0..in3`=0; `calculate`=0.
  - `value`=0; `sign`=0; `err`=0.
  - `alu_start`=0; `alu_a`=0; `alu_b`=0; `alu_op`=0.
- Reset asserted mid-job returns to S_A immediately; a later `alu_done` is ignored.
- A key event sampled at edge N takes effect at edge N: outputs change and are visible in cycle N+1.
- Enter at edge N gives S_ISSUE with `alu_start`=1 in cycle N+1, and S_WAIT in cycle N+2.
- `alu_done` sampled at edge M gives `value` updated and S_SHOW from cycle M+1. An ALU that answers in zero wait is impossible, since `alu_done` is never accepted during S_ISSUE.
- Key events arriving while in S_ISSUE/S_WAIT are dropped, not queued.

## Configuration
- `CALC_TIMEOUT_EN` defined:
  - a wait counter clears on entering S_WAIT and increments each S_WAIT cycle.
  - When it reaches `TIMEOUT` without `alu_done`: `err`=1, `value`=0, `sign`=0, go to S_SHOW.
  - If `alu_done` arrives in the same cycle the counter hits `TIMEOUT`, `alu_done` wins.
- `CALC_TIMEOUT_EN` undefined: no counter; S_WAIT is left only via `alu_done` or reset; `err` stays 0.

## Test plan
- Keys 4,2,+,1,7,Enter; ALU done after 3 cycles with 59 → `alu_a`=42, `alu_b`=17, `alu_op`=0, one `alu_start` pulse, `value`=59, `sign`=0, `state`=4.
- Keys 5,-,1,2,Enter; done with 7, `alu_neg`=1 → `in0..in3`=0,5,1,2, `calculate`=11, `sign`=11, `value`=7.
- Keys 1,2,3 → `in0`=1, `in1`=2 (third digit dropped). Then +,Enter: Enter is ignored with 0 B digits and `state` stays 1. Then Esc → all operands 0, `state`=0.
- Esc and digit 9 pressed during S_WAIT → no operand change. A stray `alu_done` while in S_A → no effect.
- With `CALC_TIMEOUT_EN`, `TIMEOUT`=8 and no `alu_done` → after 8 S_WAIT cycles, `err`=1, `value`=0, `state`=4.
- `rst` low during S_WAIT → `state`=0 and all outputs at reset values asynchronously. A subsequent `alu_done` is ignored.

Source files
------------

// File: rtl/calc_ctrl_if.sv
// ALU job handshake used by calc_ctrl. The controller side drives the operands, the opcode
// and the start pulse. The ALU side returns the result together with a done pulse.
interface calc_ctrl_if;
    logic        alu_start;
    logic [6:0]  alu_a;
    logic [6:0]  alu_b;
    logic [1:0]  alu_op;
    logic        alu_done;
    logic [13:0] alu_value;
    logic        alu_neg;

    modport master (output alu_start, alu_a, alu_b, alu_op,
                    input  alu_done, alu_value, alu_neg);
    modport slave  (input  alu_start, alu_a, alu_b, alu_op,
                    output alu_done, alu_value, alu_neg);
endinterface

// File: rtl/calc_ctrl.sv
// calc_ctrl: PS/2 numpad sequencer that builds two 2-digit operands, runs the ALU job and latches the result.
// Define CALC_TIMEOUT_EN to bound the ALU wait to TIMEOUT cycles. On expiry, err is set and an empty result is shown.
module calc_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [511:0] key_down,
    input  logic [7:0]   last_change,
    calc_ctrl_if.master  alu,
    output logic [3:0]   in0,
    output logic [3:0]   in1,
    output logic [3:0]   in2,
    output logic [3:0]   in3,
    output logic [3:0]   calculate,
    output logic [13:0]  value,
    output logic [3:0]   sign,
    output logic         err,
    output logic [2:0]   state
);
    typedef enum logic [2:0] {
        S_A = 3'd0, S_B = 3'd1, S_ISSUE = 3'd2, S_WAIT = 3'd3, S_SHOW = 3'd4
    } state_t;

    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OPER, K_ENTER, K_ESC} key_t;

    localparam logic [3:0] OP_ADD   = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] SIGN_NEG = 4'd11;

    state_t      state_q, state_d;
    logic [3:0]  in0_q, in1_q, in2_q, in3_q, in0_d, in1_d, in2_d, in3_d;
    logic [1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [3:0]  calc_q, calc_d;
    logic [13:0] value_q, value_d;
    logic [3:0]  sign_q, sign_d;
    logic        err_q, err_d;
    logic [6:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
`ifdef CALC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    key_t       key;
    logic [3:0] digit;
    logic [3:0] op_code;
    logic       press;
    logic       clear_ops;

    assign press = key_valid & key_down[{1'b0, last_change}];

    always_comb begin
        key     = K_NONE;
        digit   = 4'd0;
        op_code = OP_ADD;
        if (press) begin
            case (last_change)
                8'h70: begin key = K_DIGIT; digit = 4'd0; end
                8'h69: begin key = K_DIGIT; digit = 4'd1; end
                8'h72: begin key = K_DIGIT; digit = 4'd2; end
                8'h7A: begin key = K_DIGIT; digit = 4'd3; end
                8'h6B: begin key = K_DIGIT; digit = 4'd4; end
                8'h73: begin key = K_DIGIT; digit = 4'd5; end
                8'h74: begin key = K_DIGIT; digit = 4'd6; end
                8'h6C: begin key = K_DIGIT; digit = 4'd7; end
                8'h75: begin key = K_DIGIT; digit = 4'd8; end
                8'h7D: begin key = K_DIGIT; digit = 4'd9; end
                8'h79: begin key = K_OPER;  op_code = OP_ADD; end
                8'h7B: begin key = K_OPER;  op_code = OP_SUB; end
                8'h7C: begin key = K_OPER;  op_code = OP_MUL; end
                8'h5A: key = K_ENTER;
                8'h76: key = K_ESC;
                default: key = K_NONE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every target is defaulted to its held value first, so no path through the case can infer a latch.
        state_d   = state_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        in3_d     = in3_q;
        a_cnt_d   = a_cnt_q;
        b_cnt_d   = b_cnt_q;
        calc_d    = calc_q;
        value_d   = value_q;
        sign_d    = sign_q;
        err_d     = err_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        clear_ops = 1'b0;
`ifdef CALC_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_A: begin
                if (key == K_DIGIT && a_cnt_q != 2'd2) begin
                    in0_d   = (a_cnt_q == 2'd0) ? 4'd0 : in1_q;
                    in1_d   = digit;
                    a_cnt_d = a_cnt_q + 2'd1;
                end else if (key == K_OPER && a_cnt_q != 2'd0) begin
                    calc_d  = op_code;
                    state_d = S_B;
                end else if (key == K_ESC) begin
                    clear_ops = 1'b1;
                end
            end
            S_B: begin
                if (key == K_DIGIT && b_cnt_q != 2'd2) begin
                    in2_d   = (b_cnt_q == 2'd0) ? 4'd0 : in3_q;
                    in3_d   = digit;
                    b_cnt_d = b_cnt_q + 2'd1;
                end else if (key == K_ENTER && b_cnt_q != 2'd0) begin
                    // Operands are frozen here and stay put until the job completes.
                    alu_a_d  = 7'(in0_q) * 7'd10 + 7'(in1_q);
                    alu_b_d  = 7'(in2_q) * 7'd10 + 7'(in3_q);
                    alu_op_d = 2'(calc_q - OP_ADD);
                    state_d  = S_ISSUE;
                end else if (key == K_ESC) begin
                    clear_ops = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef CALC_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (alu.alu_done) begin
                    value_d = alu.alu_value;
                    sign_d  = alu.alu_neg ? SIGN_NEG : 4'd0;
                    err_d   = 1'b0;
                    state_d = S_SHOW;
                end
`ifdef CALC_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    value_d = '0;
                    sign_d  = '0;
                    state_d = S_SHOW;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_SHOW: begin
                if (key == K_ESC || key == K_DIGIT)
                    clear_ops = 1'b1;
            end
            default: state_d = S_A;
        endcase

        if (clear_ops) begin
            in0_d   = '0;
            in1_d   = '0;
            in2_d   = '0;
            in3_d   = '0;
            calc_d  = '0;
            a_cnt_d = '0;
            b_cnt_d = '0;
            state_d = S_A;
        end
        // In S_SHOW, a digit press also becomes the first digit of the new A operand.
        if (state_q == S_SHOW && key == K_DIGIT) begin
            in1_d   = digit;
            a_cnt_d = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_A;
            in0_q    <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            in3_q    <= '0;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            calc_q   <= '0;
            value_q  <= '0;
            sign_q   <= '0;
            err_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
`ifdef CALC_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            in3_q    <= in3_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
            calc_q   <= calc_d;
            value_q  <= value_d;
            sign_q   <= sign_d;
            err_q    <= err_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
`ifdef CALC_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign alu.alu_start = (state_q == S_ISSUE);
    assign alu.alu_a     = alu_a_q;
    assign alu.alu_b     = alu_b_q;
    assign alu.alu_op    = alu_op_q;
    assign in0           = in0_q;
    assign in1           = in1_q;
    assign in2           = in2_q;
    assign in3           = in3_q;
    assign calculate     = calc_q;
    assign value         = value_q;
    assign sign          = sign_q;
    assign err           = err_q;
    assign state         = state_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl. Expected ALU jobs and results go through scoreboard queues.
// The DUT is built with TIMEOUT=8, which only matters when CALC_TIMEOUT_EN is defined.
module tb_calc_ctrl;
    localparam logic [7:0] K_ADD = 8'h79, K_SUB = 8'h7B, K_MUL = 8'h7C;
    localparam logic [7:0] K_ENT = 8'h5A, K_ESC = 8'h76;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [511:0] key_down = '0;
    logic [7:0]   last_change = '0;
    logic [3:0]   in0, in1, in2, in3, calculate, sign;
    logic [13:0]  value;
    logic         err;
    logic [2:0]   state;

    calc_ctrl_if alu();

    int n_tests = 0;
    int n_fail = 0;
    int start_cnt = 0;

    typedef struct { int a; int b; int op; } job_t;
    typedef struct { int value; int sign; } res_t;
    job_t job_q[$];
    res_t res_q[$];
    logic [7:0] dig_code [10];

    calc_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_down(key_down),
        .last_change(last_change), .alu(alu.master),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .calculate(calculate),
        .value(value), .sign(sign), .err(err), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (alu.alu_start === 1'b1) start_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic press_raw(input logic [7:0] code, input logic down);
        @(negedge clk);
        key_valid = 1'b1;
        last_change = code;
        key_down = '0;
        key_down[code] = down;
        @(negedge clk);
        key_valid = 1'b0;
        key_down = '0;
    endtask

    task automatic press(input logic [7:0] code);
        press_raw(code, 1'b1);
    endtask

    task automatic enter_num(input int val, input int nd);
        if (nd == 2) press(dig_code[val / 10]);
        press(dig_code[val % 10]);
    endtask

    task automatic pulse_done(input int v, input logic neg);
        @(negedge clk);
        alu.alu_done = 1'b1;
        alu.alu_value = 14'(v);
        alu.alu_neg = neg;
        @(negedge clk);
        alu.alu_done = 1'b0;
        alu.alu_neg = 1'b0;
    endtask

    task automatic run_job(input string name, input int a, input int a_nd, input int op,
                           input int b, input int b_nd, input int latency,
                           input int result, input logic neg, input bit disturb);
        logic [19:0] exp_ops;
        int starts0;
        job_t j;
        res_t r;
        exp_ops = {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10), 4'(10 + op)};
        enter_num(a, a_nd);
        press(op == 0 ? K_ADD : (op == 1 ? K_SUB : K_MUL));
        enter_num(b, b_nd);
        n_tests++;
        if ({in0, in1, in2, in3, calculate} !== exp_ops || state !== 3'd1) begin
            n_fail++;
            $display("FAIL %s entry: got ops=%h state=%0d want ops=%h state=1",
                     name, {in0, in1, in2, in3, calculate}, state, exp_ops);
        end
        job_q.push_back('{a, b, op});
        starts0 = start_cnt;
        press(K_ENT);
        n_tests++;
        if (state !== 3'd2 || alu.alu_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s issue: got state=%0d start=%b want state=2 start=1",
                     name, state, alu.alu_start);
        end
        j = job_q.pop_front();
        n_tests++;
        if (alu.alu_a !== 7'(j.a) || alu.alu_b !== 7'(j.b) || alu.alu_op !== 2'(j.op)) begin
            n_fail++;
            $display("FAIL %s operands: got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d",
                     name, alu.alu_a, alu.alu_b, alu.alu_op, j.a, j.b, j.op);
        end
        if (disturb) begin
            press(K_ESC);
            press(dig_code[9]);
        end
        repeat (latency) @(negedge clk);
        n_tests++;
        if (state !== 3'd3 || alu.alu_start !== 1'b0 || alu.alu_a !== 7'(j.a) ||
            alu.alu_b !== 7'(j.b) || alu.alu_op !== 2'(j.op) ||
            {in0, in1, in2, in3, calculate} !== exp_ops || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: got state=%0d start=%b a=%0d b=%0d ops=%h err=%b want state=3 start=0 a=%0d b=%0d ops=%h err=0",
                     name, state, alu.alu_start, alu.alu_a, alu.alu_b,
                     {in0, in1, in2, in3, calculate}, err, j.a, j.b, exp_ops);
        end
        res_q.push_back('{result, neg ? 11 : 0});
        pulse_done(result, neg);
        r = res_q.pop_front();
        n_tests++;
        if (value !== 14'(r.value) || sign !== 4'(r.sign) || err !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL %s result: got value=%0d sign=%0d err=%b state=%0d want value=%0d sign=%0d err=0 state=4",
                     name, value, sign, err, state, r.value, r.sign);
        end
        n_tests++;
        if (start_cnt - starts0 !== 1) begin
            n_fail++;
            $display("FAIL %s start_pulses: got %0d want 1", name, start_cnt - starts0);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({state, in0, in1, in2, in3, calculate, value, sign, err} !== '0 ||
            {alu.alu_start, alu.alu_a, alu.alu_b, alu.alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got state=%0d ops=%h value=%0d sign=%0d err=%b start=%b a=%0d b=%0d op=%0d want all 0",
                     state, {in0, in1, in2, in3, calculate}, value, sign, err,
                     alu.alu_start, alu.alu_a, alu.alu_b, alu.alu_op);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d want 0", state);
        end
    endtask

    task automatic test_show_digit();
        press(dig_code[3]);
        n_tests++;
        if (state !== 3'd0 || {in0, in1, in2, in3, calculate} !== 20'h03000 || value !== 14'd59) begin
            n_fail++;
            $display("FAIL show_digit: got state=%0d ops=%h value=%0d want state=0 ops=03000 value=59",
                     state, {in0, in1, in2, in3, calculate}, value);
        end
        press(dig_code[4]);
        n_tests++;
        if ({in0, in1} !== 8'h34) begin
            n_fail++;
            $display("FAIL show_second_digit: got %h want 34", {in0, in1});
        end
        press(K_ESC);
        n_tests++;
        if ({in0, in1, in2, in3, calculate} !== '0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL esc_in_a: got ops=%h state=%0d want 0",
                     {in0, in1, in2, in3, calculate}, state);
        end
    endtask

    task automatic test_digit_limit();
        press(K_ESC);
        n_tests++;
        if ({in0, in1, in2, in3, calculate} !== '0 || state !== 3'd0 ||
            value !== 14'd7 || sign !== 4'd11) begin
            n_fail++;
            $display("FAIL esc_in_show: got ops=%h state=%0d value=%0d sign=%0d want ops=0 state=0 value=7 sign=11",
                     {in0, in1, in2, in3, calculate}, state, value, sign);
        end
        press(K_ADD);
        press_raw(dig_code[1], 1'b0);
        n_tests++;
        if (state !== 3'd0 || {in0, in1, calculate} !== '0) begin
            n_fail++;
            $display("FAIL op_no_digits: got state=%0d ops=%h want state=0 ops=0",
                     state, {in0, in1, calculate});
        end
        press(dig_code[1]);
        press(dig_code[2]);
        press(dig_code[3]);
        n_tests++;
        if ({in0, in1} !== 8'h12) begin
            n_fail++;
            $display("FAIL third_digit: got %h want 12", {in0, in1});
        end
        press(K_ADD);
        press(K_ENT);
        press(K_SUB);
        n_tests++;
        if (state !== 3'd1 || calculate !== 4'd10 || alu.alu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_no_b: got state=%0d calc=%0d start=%b want state=1 calc=10 start=0",
                     state, calculate, alu.alu_start);
        end
        press(K_ESC);
        n_tests++;
        if ({in0, in1, in2, in3, calculate} !== '0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL esc_in_b: got ops=%h state=%0d want 0",
                     {in0, in1, in2, in3, calculate}, state);
        end
    endtask

    task automatic test_stray_done();
        press(K_ESC);
        pulse_done(1234, 1'b1);
        n_tests++;
        if (state !== 3'd0 || value !== 14'd14 || sign !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_done: got state=%0d value=%0d sign=%0d err=%b want state=0 value=14 sign=0 err=0",
                     state, value, sign, err);
        end
    endtask

    task automatic test_timeout();
`ifdef CALC_TIMEOUT_EN
        int waited;
        waited = 0;
        enter_num(3, 1);
        press(K_ADD);
        enter_num(4, 1);
        press(K_ENT);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state !== 3'd3) break;
            waited++;
        end
        n_tests++;
        if (waited !== 8 || err !== 1'b1 || value !== 14'd0 || sign !== 4'd0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL timeout: got wait=%0d err=%b value=%0d state=%0d want wait=8 err=1 value=0 state=4",
                     waited, err, value, state);
        end
        press(K_ESC);
        run_job("after_timeout", 7, 1, 0, 70, 2, 2, 77, 1'b0, 1'b0);
`else
        run_job("long_wait", 3, 1, 0, 4, 1, 40, 7, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_job();
        press(K_ESC);
        enter_num(25, 2);
        press(K_MUL);
        enter_num(3, 1);
        press(K_ENT);
        @(negedge clk);
        n_tests++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_job_setup: got state=%0d want 3", state);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({state, in0, in1, in2, in3, calculate, value, sign, err} !== '0 ||
            {alu.alu_start, alu.alu_a, alu.alu_b, alu.alu_op} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d ops=%h value=%0d sign=%0d err=%b a=%0d b=%0d op=%0d want all 0",
                     state, {in0, in1, in2, in3, calculate}, value, sign, err,
                     alu.alu_a, alu.alu_b, alu.alu_op);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_done(500, 1'b0);
        n_tests++;
        if (state !== 3'd0 || value !== 14'd0) begin
            n_fail++;
            $display("FAIL done_after_reset: got state=%0d value=%0d want state=0 value=0", state, value);
        end
    endtask

    initial begin
        dig_code = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        alu.alu_done = 1'b0;
        alu.alu_value = '0;
        alu.alu_neg = 1'b0;
        test_reset();
        run_job("add", 42, 2, 0, 17, 2, 3, 59, 1'b0, 1'b0);
        test_show_digit();
        run_job("sub", 5, 1, 1, 12, 2, 3, 7, 1'b1, 1'b0);
        test_digit_limit();
        run_job("mul_max", 99, 2, 2, 99, 2, 1, 9801, 1'b0, 1'b0);
        press(K_ESC);
        run_job("busy_keys", 8, 1, 0, 6, 1, 6, 14, 1'b0, 1'b1);
        test_stray_done();
        test_timeout();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
